// File: rtl/scroll_pkg.sv
// Shared types and constants for the banner scroll sequencer: state encoding,
// position width and the default geometry of the two banners.
package scroll_pkg;

    localparam int POS_W            = 13;
    localparam int OUT_W            = 12;
    localparam int DIV_W            = 8;
    localparam int DEF_START_X      = 640;
    localparam int DEF_LINE2_OFFSET = 3060;
    localparam int DEF_TEXT1_W      = 315;
    localparam int DEF_TEXT2_W      = 270;
    localparam int DEF_FRAME_DIV    = 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2,
        ST_HOLD   = 2'd3
    } state_t;

    typedef logic signed [POS_W-1:0] pos_t;

    // Pixel step per update for a given speed select (1, 2, 4 or 8).
    function automatic pos_t step_of(input logic [1:0] speed);
        pos_t step;
        case (speed)
            2'd0:    step = 13'sd1;
            2'd1:    step = 13'sd2;
            2'd2:    step = 13'sd4;
            2'd3:    step = 13'sd8;
            default: step = 13'sd1;
        endcase
        return step;
    endfunction

endpackage

// File: rtl/frame_divider.sv
// Divides frame_tick by FRAME_DIV; upd_stb is combinational so a position
// update lands on the edge right after the qualifying tick.
module frame_divider
    import scroll_pkg::*;
#(
    parameter int FRAME_DIV = DEF_FRAME_DIV
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic clr,
    input  logic hold,
    output logic upd_stb
);

    localparam logic [DIV_W-1:0] LAST_C = DIV_W'(FRAME_DIV - 1);
    localparam logic [DIV_W-1:0] ONE_C  = DIV_W'(1);
    localparam logic [DIV_W-1:0] ZERO_C = DIV_W'(0);

    logic [DIV_W-1:0] cnt_r;
    logic             at_last_s;

    assign at_last_s = (cnt_r == LAST_C);
    assign upd_stb   = tick & ~clr & ~hold & at_last_s;

    // Tick counter: clear wins, hold freezes the count without losing it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= ZERO_C;
        end else if (clr) begin
            cnt_r <= ZERO_C;
        end else if (tick && !hold) begin
            cnt_r <= at_last_s ? ZERO_C : (cnt_r + ONE_C);
        end else begin
            cnt_r <= cnt_r;
        end
    end

endmodule

// File: rtl/scroll_sequencer.sv
// Base x positions for two scrolling banners, updated only at frame boundaries.
// Optional centre hold of line 1 is enabled by defining SCROLL_HOLD_EN.
module scroll_sequencer
    import scroll_pkg::*;
#(
    parameter int START_X      = DEF_START_X,
    parameter int LINE2_OFFSET = DEF_LINE2_OFFSET,
    parameter int TEXT1_W      = DEF_TEXT1_W,
    parameter int TEXT2_W      = DEF_TEXT2_W,
    parameter int FRAME_DIV    = DEF_FRAME_DIV
`ifdef SCROLL_HOLD_EN
    ,
    parameter int HOLD_X       = 200,
    parameter int HOLD_FRAMES  = 3
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             frame_tick,
    input  logic             scroll_en,
    input  logic             pause,
    input  logic [1:0]       speed,
    output logic [OUT_W-1:0] base_horz1,
    output logic [OUT_W-1:0] base_horz2,
    output logic             wrap1,
    output logic             wrap2,
    output logic             running
);

    localparam pos_t RELOAD1_C = pos_t'(START_X);
    localparam pos_t RELOAD2_C = pos_t'(START_X + LINE2_OFFSET);
    localparam pos_t LIM1_C    = pos_t'(-TEXT1_W);
    localparam pos_t LIM2_C    = pos_t'(-TEXT2_W);

    state_t state_r, state_s;
    pos_t   pos1_r, pos1_s, pos2_r, pos2_s;
    pos_t   step_s, nxt1_s, nxt2_s;
    logic   wrap1_r, wrap1_s, wrap2_r, wrap2_s, running_r;
    logic   wrap1_hit_s, wrap2_hit_s;
    logic   div_clr_s, div_hold_s, upd_stb_s;

`ifdef SCROLL_HOLD_EN
    localparam pos_t             HOLD_X_C    = pos_t'(HOLD_X);
    localparam logic [DIV_W-1:0] HOLD_LAST_C = DIV_W'(HOLD_FRAMES - 1);
    localparam logic [DIV_W-1:0] HOLD_ONE_C  = DIV_W'(1);
    localparam logic [DIV_W-1:0] HOLD_ZERO_C = DIV_W'(0);
    logic             armed_r, armed_s, cross_s;
    logic [DIV_W-1:0] hold_cnt_r, hold_cnt_s;
`endif

    // The divider only advances while scrolling or holding and not paused.
    assign div_clr_s   = (state_r == ST_IDLE) | ~scroll_en;
    assign div_hold_s  = pause | ~((state_r == ST_RUN) | (state_r == ST_HOLD));

    assign step_s      = step_of(speed);
    assign nxt1_s      = pos1_r - step_s;
    assign nxt2_s      = pos2_r - step_s;
    assign wrap1_hit_s = (nxt1_s < LIM1_C);
    assign wrap2_hit_s = (nxt2_s < LIM2_C);

`ifdef SCROLL_HOLD_EN
    assign cross_s = armed_r & (pos1_r > HOLD_X_C) & (nxt1_s <= HOLD_X_C) & ~wrap1_hit_s;
`endif

    frame_divider #(
        .FRAME_DIV (FRAME_DIV)
    ) u_div (
        .clk     (clk),
        .rst_n   (rst_n),
        .tick    (frame_tick),
        .clr     (div_clr_s),
        .hold    (div_hold_s),
        .upd_stb (upd_stb_s)
    );

    // Next-state and next-position logic; scroll_en=0 overrides everything.
    always_comb begin
        state_s = state_r;
        pos1_s  = pos1_r;
        pos2_s  = pos2_r;
        wrap1_s = 1'b0;
        wrap2_s = 1'b0;
`ifdef SCROLL_HOLD_EN
        armed_s    = armed_r;
        hold_cnt_s = hold_cnt_r;
`endif
        if (!scroll_en) begin
            state_s = ST_IDLE;
            pos1_s  = RELOAD1_C;
            pos2_s  = RELOAD2_C;
`ifdef SCROLL_HOLD_EN
            armed_s    = 1'b1;
            hold_cnt_s = HOLD_ZERO_C;
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_s = ST_RUN;
                    pos1_s  = RELOAD1_C;
                    pos2_s  = RELOAD2_C;
                end
                ST_RUN: begin
                    if (pause) begin
                        state_s = ST_PAUSED;
                    end else if (upd_stb_s) begin
                        if (wrap1_hit_s) begin
                            pos1_s  = RELOAD1_C;
                            wrap1_s = 1'b1;
`ifdef SCROLL_HOLD_EN
                            armed_s = 1'b1;
`endif
                        end else begin
                            pos1_s = nxt1_s;
                        end
                        if (wrap2_hit_s) begin
                            pos2_s  = RELOAD1_C;
                            wrap2_s = 1'b1;
                        end else begin
                            pos2_s = nxt2_s;
                        end
`ifdef SCROLL_HOLD_EN
                        if (cross_s) begin
                            state_s    = ST_HOLD;
                            armed_s    = 1'b0;
                            hold_cnt_s = HOLD_ZERO_C;
                        end else begin
                            state_s = ST_RUN;
                        end
`endif
                    end else begin
                        state_s = ST_RUN;
                    end
                end
                ST_PAUSED: begin
                    if (!pause) begin
                        state_s = ST_RUN;
                    end else begin
                        state_s = ST_PAUSED;
                    end
                end
                ST_HOLD: begin
`ifdef SCROLL_HOLD_EN
                    if (upd_stb_s) begin
                        if (hold_cnt_r == HOLD_LAST_C) begin
                            state_s    = ST_RUN;
                            hold_cnt_s = HOLD_ZERO_C;
                        end else begin
                            hold_cnt_s = hold_cnt_r + HOLD_ONE_C;
                        end
                    end else begin
                        state_s = ST_HOLD;
                    end
`else
                    state_s = ST_IDLE;
`endif
                end
                default: state_s = ST_IDLE;
            endcase
        end
    end

    // State, position and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            pos1_r    <= RELOAD1_C;
            pos2_r    <= RELOAD2_C;
            wrap1_r   <= 1'b0;
            wrap2_r   <= 1'b0;
            running_r <= 1'b0;
        end else begin
            state_r   <= state_s;
            pos1_r    <= pos1_s;
            pos2_r    <= pos2_s;
            wrap1_r   <= wrap1_s;
            wrap2_r   <= wrap2_s;
            running_r <= (state_s == ST_RUN) | (state_s == ST_HOLD);
        end
    end

`ifdef SCROLL_HOLD_EN
    // Hold arming flag and hold duration counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed_r    <= 1'b1;
            hold_cnt_r <= HOLD_ZERO_C;
        end else begin
            armed_r    <= armed_s;
            hold_cnt_r <= hold_cnt_s;
        end
    end
`endif

    assign base_horz1 = pos1_r[OUT_W-1:0];
    assign base_horz2 = pos2_r[OUT_W-1:0];
    assign wrap1      = wrap1_r;
    assign wrap2      = wrap2_r;
    assign running    = running_r;

endmodule

// File: tb/tb_scroll_sequencer.sv
// Randomized bench for scroll_sequencer (FRAME_DIV=1 and FRAME_DIV=3 instances)
// against a frame-level behavioural model, plus directed literal checks.
module tb_scroll_sequencer;

    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSED = 2, M_HOLD = 3;
    localparam int FD[2] = '{1, 3};

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        frame_tick = 1'b0;
    logic        scroll_en = 1'b0;
    logic        pause = 1'b0;
    logic [1:0]  speed = 2'd0;
    logic [11:0] bh1 [2];
    logic [11:0] bh2 [2];
    logic        w1 [2];
    logic        w2 [2];
    logic        run [2];

    int  n_checks = 0;
    int  n_fail = 0;
    bit  chk_on = 1'b0;

    int  m_mode [2];
    int  m_p1 [2];
    int  m_p2 [2];
    int  m_div [2];
    int  m_hc [2];
    bit  m_w1 [2];
    bit  m_w2 [2];
    bit  m_armed [2];

    always #5 clk = ~clk;

    scroll_sequencer #(.FRAME_DIV(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .scroll_en(scroll_en),
        .pause(pause), .speed(speed), .base_horz1(bh1[0]), .base_horz2(bh2[0]),
        .wrap1(w1[0]), .wrap2(w2[0]), .running(run[0]));

    scroll_sequencer #(.FRAME_DIV(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .scroll_en(scroll_en),
        .pause(pause), .speed(speed), .base_horz1(bh1[1]), .base_horz2(bh2[1]),
        .wrap1(w1[1]), .wrap2(w2[1]), .running(run[1]));

    task automatic chk(input string name, input int inst, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: actual=%0d required=%0d at %0t", name, inst, act, exp, $time);
        end
    endtask

    // One position update of the banners, straight from the scrolling rules.
    task automatic do_update(input int i);
        int s, n1, n2;
        s  = 1 << speed;
        n1 = m_p1[i] - s;
        n2 = m_p2[i] - s;
`ifdef SCROLL_HOLD_EN
        if (m_armed[i] && m_p1[i] > 200 && n1 <= 200 && n1 >= -315) begin
            m_mode[i] = M_HOLD; m_armed[i] = 1'b0; m_hc[i] = 0;
        end
`endif
        if (n1 < -315) begin m_p1[i] = 640; m_w1[i] = 1'b1; m_armed[i] = 1'b1; end
        else m_p1[i] = n1;
        if (n2 < -270) begin m_p2[i] = 640; m_w2[i] = 1'b1; end
        else m_p2[i] = n2;
    endtask

    task automatic count_tick(input int i, output bit fire);
        m_div[i]++;
        fire = (m_div[i] == FD[i]);
        if (fire) m_div[i] = 0;
    endtask

    task automatic model_reset(input int i);
        m_mode[i] = M_IDLE; m_p1[i] = 640; m_p2[i] = 3700; m_div[i] = 0;
        m_hc[i] = 0; m_w1[i] = 1'b0; m_w2[i] = 1'b0; m_armed[i] = 1'b1;
    endtask

    task automatic model_step(input int i);
        bit fire;
        m_w1[i] = 1'b0;
        m_w2[i] = 1'b0;
        if (!scroll_en) begin
            model_reset(i);
        end else begin
            case (m_mode[i])
                M_IDLE:   m_mode[i] = M_RUN;
                M_RUN: begin
                    if (pause) m_mode[i] = M_PAUSED;
                    else if (frame_tick) begin
                        count_tick(i, fire);
                        if (fire) do_update(i);
                    end
                end
                M_PAUSED: if (!pause) m_mode[i] = M_RUN;
                default: begin
                    if (!pause && frame_tick) begin
                        count_tick(i, fire);
                        if (fire) begin
                            m_hc[i]++;
                            if (m_hc[i] == 3) begin m_mode[i] = M_RUN; m_hc[i] = 0; end
                        end
                    end
                end
            endcase
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) model_reset(i);
            else model_step(i);
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            for (int i = 0; i < 2; i++) begin
                chk("base_horz1", i, int'(bh1[i]), m_p1[i] & 32'hFFF);
                chk("base_horz2", i, int'(bh2[i]), m_p2[i] & 32'hFFF);
                chk("wrap1", i, int'(w1[i]), int'(m_w1[i]));
                chk("wrap2", i, int'(w2[i]), int'(m_w2[i]));
                chk("running", i, int'(run[i]), int'(m_mode[i] == M_RUN || m_mode[i] == M_HOLD));
            end
        end
    end

    task automatic tick_n(input int n);
        for (int k = 0; k < n; k++) begin
            frame_tick = 1'b1;
            @(negedge clk);
            frame_tick = 1'b0;
            @(negedge clk);
        end
    endtask

    initial begin
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_b1", 0, int'(bh1[0]), 640);
        chk("rst_b2", 0, int'(bh2[0]), 3700);
        chk("rst_run", 0, int'(run[0]), 0);
        rst_n = 1'b1;
        chk_on = 1'b1;

        scroll_en = 1'b1;
        @(negedge clk);
        tick_n(3);
        chk("basic_b1", 0, int'(bh1[0]), 637);
        chk("basic_b2", 0, int'(bh2[0]), 3697);
        chk("basic_b1", 1, int'(bh1[1]), 639);

        tick_n(1);
        pause = 1'b1;
        tick_n(5);
        chk("pause_b1", 0, int'(bh1[0]), 636);
        pause = 1'b0;
        @(negedge clk);
        tick_n(1);
        chk("resume_b1", 0, int'(bh1[0]), 635);
        chk("resume_div", 1, int'(bh1[1]), 639);
        tick_n(1);
        chk("resume_div_b1", 1, int'(bh1[1]), 638);

`ifndef SCROLL_HOLD_EN
        tick_n(949);
        chk("edge_b1", 0, int'(bh1[0]), 32'hEC5);
        chk("edge_b2", 0, int'(bh2[0]), 2745);
        chk("edge_b1", 1, int'(bh1[1]), 322);
        chk("edge_b2", 1, int'(bh2[1]), 3382);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        chk("wrap_b1", 0, int'(bh1[0]), 640);
        chk("wrap_pulse", 0, int'(w1[0]), 1);
        chk("wrap_b2", 0, int'(bh2[0]), 2744);
        @(negedge clk);
`endif

        scroll_en = 1'b0; frame_tick = 1'b1; pause = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0; pause = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk("stop_b1", i, int'(bh1[i]), 640);
            chk("stop_b2", i, int'(bh2[i]), 3700);
            chk("stop_run", i, int'(run[i]), 0);
            chk("stop_wrap1", i, int'(w1[i]), 0);
        end

`ifdef SCROLL_HOLD_EN
        scroll_en = 1'b1;
        @(negedge clk);
        speed = 2'd3;
        tick_n(55);
        chk("hold_b1", 0, int'(bh1[0]), 200);
        chk("hold_b2", 0, int'(bh2[0]), 3260);
        tick_n(3);
        chk("held_b1", 0, int'(bh1[0]), 200);
        chk("held_b2", 0, int'(bh2[0]), 3260);
        tick_n(1);
        chk("release_b1", 0, int'(bh1[0]), 192);
        chk("release_b2", 0, int'(bh2[0]), 3252);
`endif

        scroll_en = 1'b1;
        speed = 2'd3;
        for (int c = 0; c < 8000; c++) begin
            if (c == 3000) begin
                #2 rst_n = 1'b0;
                #1;
                chk("async_b1", 0, int'(bh1[0]), 640);
                chk("async_b2", 0, int'(bh2[0]), 3700);
                chk("async_run", 0, int'(run[0]), 0);
                chk("async_wrap", 0, int'(w1[0]) + int'(w2[0]), 0);
                @(negedge clk);
                rst_n = 1'b1;
            end
            if (scroll_en) scroll_en = ($urandom % 3000) != 0;
            else scroll_en = ($urandom % 4) == 0;
            if (pause) pause = ($urandom % 6) != 0;
            else pause = ($urandom % 150) == 0;
            if (($urandom % 400) == 0) speed = 2'($urandom % 4);
            frame_tick = ($urandom % 3) == 0;
            @(negedge clk);
        end
        frame_tick = 1'b0;
        @(negedge clk);
        chk_on = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
